// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the execute-stage output bundle.
// Imported by the execute stage, its interface users and the condition evaluator.
package y86_pkg;

    localparam int XLEN = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_fun_t;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [3:0] REG_NONE = 4'hF;

    // {ZF,SF,OF}
    localparam logic [2:0] CC_RESET = 3'b100;

    typedef struct packed {
        logic            valid;
        logic [3:0]      icode;
        logic            cnd;
        logic [XLEN-1:0] val_e;
        logic [XLEN-1:0] val_a;
        logic [3:0]      dst_e;
        logic [3:0]      dst_m;
    } ex_bundle_t;

    localparam ex_bundle_t BUBBLE = '{
        valid: 1'b0,
        icode: I_NOP,
        cnd:   1'b0,
        val_e: 64'd0,
        val_a: 64'd0,
        dst_e: REG_NONE,
        dst_m: REG_NONE
    };

endpackage

// File: rtl/y86_execute_stage_if.sv
// Decode-to-execute inputs, pipeline control, and the registered execute bundle.
// The pipeline control side uses master; the execute stage uses slave.
interface y86_execute_stage_if #(parameter int WIDTH = 64);

    logic             d_valid;
    logic [3:0]       d_icode;
    logic [3:0]       d_ifun;
    logic [WIDTH-1:0] d_valA;
    logic [WIDTH-1:0] d_valB;
    logic [WIDTH-1:0] d_valC;
    logic [3:0]       d_dstE;
    logic [3:0]       d_dstM;
    logic             stall;
    logic             flush;
    logic             cc_hold;

    logic             e_valid;
    logic [3:0]       e_icode;
    logic             e_cnd;
    logic [WIDTH-1:0] e_valE;
    logic [WIDTH-1:0] e_valA;
    logic [3:0]       e_dstE;
    logic [3:0]       e_dstM;
    logic [2:0]       cc_out;

    modport master (
        output d_valid, d_icode, d_ifun, d_valA, d_valB, d_valC, d_dstE, d_dstM,
        output stall, flush, cc_hold,
        input  e_valid, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM, cc_out
    );

    modport slave (
        input  d_valid, d_icode, d_ifun, d_valA, d_valB, d_valC, d_dstE, d_dstM,
        input  stall, flush, cc_hold,
        output e_valid, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM, cc_out
    );

endinterface

// File: rtl/alu.sv
// 64-bit combinational ALU: add, sub (a - b), and, xor with signed overflow.
// Overflow is only meaningful for add and sub.
module alu (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [1:0]  alufun,
    output logic [63:0] result,
    output logic        overflow
);

    // Result and two's-complement overflow per function
    always_comb begin
        result   = 64'd0;
        overflow = 1'b0;
        case (alufun)
            2'b00: begin
                result   = a + b;
                overflow = (a[63] == b[63]) && (result[63] != a[63]);
            end
            2'b01: begin
                result   = a - b;
                overflow = (a[63] != b[63]) && (result[63] != a[63]);
            end
            2'b10: result = a & b;
            2'b11: result = a ^ b;
            default: begin
                result   = 64'd0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/y86_execute_stage_cond_eval.sv
// Jump / conditional-move condition from the current {ZF,SF,OF} and ifun.
// Unknown condition codes evaluate false.
module cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic zf_s, sf_s, of_s;

    assign zf_s = cc[2];
    assign sf_s = cc[1];
    assign of_s = cc[0];

    // Condition decode
    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = (sf_s ^ of_s) | zf_s;
            C_L:      cnd = sf_s ^ of_s;
            C_E:      cnd = zf_s;
            C_NE:     cnd = ~zf_s;
            C_GE:     cnd = ~(sf_s ^ of_s);
            C_G:      cnd = ~(sf_s ^ of_s) & ~zf_s;
            default:  cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: operand/function select, condition codes, and the
// registered bundle handed to the memory stage. WIDTH must be 64 to match alu.
module y86_execute_stage
    import y86_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int STACK_STEP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    y86_execute_stage_if.slave ex
);

    logic [WIDTH-1:0] alu_a_s;
    logic [WIDTH-1:0] alu_b_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_ovf_s;
    alu_fun_t         alu_fun_s;
    logic             cond_s;
    logic             cnd_s;
    logic [2:0]       cc_new_s;
    logic             cc_we_s;
    logic [2:0]       cc_r;
    ex_bundle_t       ex_next_s;
    ex_bundle_t       ex_r;

    // ALU function and operand selection from the decoded instruction
    always_comb begin
        alu_fun_s = ALU_ADD;
        alu_a_s   = '0;
        alu_b_s   = '0;
        if (ex.d_icode == I_OPQ) begin
            alu_fun_s = alu_fun_t'(ex.d_ifun[1:0]);
        end else begin
            alu_fun_s = ALU_ADD;
        end
        case (ex.d_icode)
            I_RRMOVQ, I_OPQ:              alu_a_s = ex.d_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a_s = ex.d_valC;
            I_CALL, I_PUSHQ:              alu_a_s = '0 - WIDTH'(STACK_STEP);
            I_RET, I_POPQ:                alu_a_s = WIDTH'(STACK_STEP);
            default:                      alu_a_s = '0;
        endcase
        case (ex.d_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_RET, I_PUSHQ, I_POPQ:       alu_b_s = ex.d_valB;
            default:                      alu_b_s = '0;
        endcase
    end

    // Port a takes aluB so that subq yields valB - valA
    alu u_alu (
        .a        (alu_b_s),
        .b        (alu_a_s),
        .alufun   (alu_fun_s),
        .result   (alu_res_s),
        .overflow (alu_ovf_s)
    );

    // Conditions always look at the CC as it stands before this instruction
    cond_eval u_cond_eval (
        .cc   (cc_r),
        .ifun (ex.d_ifun),
        .cnd  (cond_s)
    );

    // New flags, CC write enable and the effective Cnd
    always_comb begin
        cc_new_s = {(alu_res_s == '0), alu_res_s[WIDTH-1],
                    ((alu_fun_s == ALU_ADD) || (alu_fun_s == ALU_SUB)) ? alu_ovf_s : 1'b0};
        cc_we_s  = ex.d_valid && (ex.d_icode == I_OPQ) && !ex.stall && !ex.flush && !ex.cc_hold;
        if ((ex.d_icode == I_RRMOVQ) || (ex.d_icode == I_JXX)) begin
            cnd_s = cond_s;
        end else begin
            cnd_s = 1'b1;
        end
    end

    // Next output bundle; invalid icodes pass through with a zero valE
    always_comb begin
        ex_next_s = BUBBLE;
        if (ex.d_valid && !ex.flush) begin
            ex_next_s.valid = 1'b1;
            ex_next_s.icode = ex.d_icode;
            ex_next_s.cnd   = cnd_s;
            ex_next_s.val_e = (ex.d_icode > I_POPQ) ? '0 : alu_res_s;
            ex_next_s.val_a = ex.d_valA;
            ex_next_s.dst_e = ((ex.d_icode == I_RRMOVQ) && !cnd_s) ? REG_NONE : ex.d_dstE;
            ex_next_s.dst_m = ex.d_dstM;
        end else begin
            ex_next_s = BUBBLE;
        end
    end

    // Output bundle register; stall holds it even if flush is also raised
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r <= BUBBLE;
        end else if (!ex.stall) begin
            ex_r <= ex_next_s;
        end else begin
            ex_r <= ex_r;
        end
    end

    // Condition-code register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_r <= CC_RESET;
        end else if (cc_we_s) begin
            cc_r <= cc_new_s;
        end else begin
            cc_r <= cc_r;
        end
    end

    assign ex.e_valid = ex_r.valid;
    assign ex.e_icode = ex_r.icode;
    assign ex.e_cnd   = ex_r.cnd;
    assign ex.e_valE  = ex_r.val_e;
    assign ex.e_valA  = ex_r.val_a;
    assign ex.e_dstE  = ex_r.dst_e;
    assign ex.e_dstM  = ex_r.dst_m;
    assign ex.cc_out  = cc_r;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Directed vector bench for y86_execute_stage: a table of instructions with
// hand-computed results, then an asynchronous mid-cycle reset sequence.
module tb_y86_execute_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    y86_execute_stage_if #(.WIDTH(64)) bus ();

    y86_execute_stage #(.WIDTH(64), .STACK_STEP(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex    (bus)
    );

    typedef struct {
        logic        v;
        logic [3:0]  ic, fn;
        logic [63:0] a, b, c;
        logic [3:0]  de, dm;
        logic        st, fl, ch;
        logic        x_v;
        logic [3:0]  x_ic;
        logic        x_cnd;
        logic [63:0] x_e, x_a;
        logic [3:0]  x_de, x_dm;
        logic [2:0]  x_cc;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(
        input logic v, input logic [3:0] ic, input logic [3:0] fn,
        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
        input logic [3:0] de, input logic [3:0] dm,
        input logic st, input logic fl, input logic ch,
        input logic x_v, input logic [3:0] x_ic, input logic x_cnd,
        input logic [63:0] x_e, input logic [63:0] x_a,
        input logic [3:0] x_de, input logic [3:0] x_dm, input logic [2:0] x_cc);
        vec_t r;
        r.v = v; r.ic = ic; r.fn = fn; r.a = a; r.b = b; r.c = c;
        r.de = de; r.dm = dm; r.st = st; r.fl = fl; r.ch = ch;
        r.x_v = x_v; r.x_ic = x_ic; r.x_cnd = x_cnd; r.x_e = x_e; r.x_a = x_a;
        r.x_de = x_de; r.x_dm = x_dm; r.x_cc = x_cc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic st, input logic fl, input logic ch);
        bus.d_valid = v;  bus.d_icode = ic; bus.d_ifun = fn;
        bus.d_valA  = a;  bus.d_valB  = b;  bus.d_valC = c;
        bus.d_dstE  = de; bus.d_dstM  = dm;
        bus.stall   = st; bus.flush   = fl; bus.cc_hold = ch;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".valid"}, 64'(bus.e_valid), 64'd0);
        chk({tag, ".icode"}, 64'(bus.e_icode), 64'd1);
        chk({tag, ".cnd"},   64'(bus.e_cnd),   64'd0);
        chk({tag, ".valE"},  bus.e_valE,       64'd0);
        chk({tag, ".valA"},  bus.e_valA,       64'd0);
        chk({tag, ".dstE"},  64'(bus.e_dstE),  64'hF);
        chk({tag, ".dstM"},  64'(bus.e_dstM),  64'hF);
        chk({tag, ".cc"},    64'(bus.cc_out),  64'b100);
    endtask

    initial begin
        // Sequence carries CC from one vector to the next
        vecs[0]  = mk(1, 4'h6, 4'h1, 64'd4, 64'd11, 64'd0, 4'h3, 4'hF, 0, 0, 0,
                      1, 4'h6, 1, 64'd7, 64'd4, 4'h3, 4'hF, 3'b000);
        vecs[1]  = mk(1, 4'h6, 4'h1, 64'd11, 64'd4, 64'd0, 4'h3, 4'hF, 0, 0, 0,
                      1, 4'h6, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd11, 4'h3, 4'hF, 3'b010);
        vecs[2]  = mk(1, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h3, 4'hF, 0, 0, 0,
                      1, 4'h6, 1, 64'h8000_0000_0000_0000, 64'd1, 4'h3, 4'hF, 3'b011);
        vecs[3]  = mk(1, 4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF, 0, 0, 0,
                      1, 4'h7, 0, 64'd0, 64'd0, 4'hF, 4'hF, 3'b011);
        vecs[4]  = mk(1, 4'h6, 4'h2, 64'hF0, 64'h0F, 64'd0, 4'h5, 4'hF, 0, 0, 0,
                      1, 4'h6, 1, 64'd0, 64'hF0, 4'h5, 4'hF, 3'b100);
        vecs[5]  = mk(1, 4'h7, 4'h1, 64'd0, 64'd0, 64'h80, 4'hF, 4'hF, 0, 0, 0,
                      1, 4'h7, 1, 64'd0, 64'd0, 4'hF, 4'hF, 3'b100);
        vecs[6]  = mk(1, 4'h2, 4'h4, 64'h55, 64'd0, 64'd0, 4'h3, 4'hF, 0, 0, 0,
                      1, 4'h2, 0, 64'h55, 64'h55, 4'hF, 4'hF, 3'b100);
        vecs[7]  = mk(1, 4'hA, 4'h0, 64'h77, 64'h100, 64'd0, 4'h4, 4'hF, 0, 0, 0,
                      1, 4'hA, 1, 64'hF8, 64'h77, 4'h4, 4'hF, 3'b100);
        vecs[8]  = mk(1, 4'hB, 4'h0, 64'h100, 64'h100, 64'd0, 4'h4, 4'h5, 0, 0, 0,
                      1, 4'hB, 1, 64'h108, 64'h100, 4'h4, 4'h5, 3'b100);
        vecs[9]  = mk(1, 4'h6, 4'h3, 64'hFF, 64'h0F, 64'd0, 4'h1, 4'hF, 0, 0, 0,
                      1, 4'h6, 1, 64'hF0, 64'hFF, 4'h1, 4'hF, 3'b000);
        vecs[10] = mk(1, 4'h3, 4'h0, 64'd0, 64'h999, 64'h1234, 4'h2, 4'hF, 0, 0, 0,
                      1, 4'h3, 1, 64'h1234, 64'd0, 4'h2, 4'hF, 3'b000);
        vecs[11] = mk(1, 4'h5, 4'h0, 64'd0, 64'h200, 64'h10, 4'hF, 4'h6, 0, 0, 0,
                      1, 4'h5, 1, 64'h210, 64'd0, 4'hF, 4'h6, 3'b000);
        vecs[12] = mk(1, 4'h8, 4'h0, 64'd0, 64'h100, 64'h400, 4'h4, 4'hF, 0, 0, 0,
                      1, 4'h8, 1, 64'hF8, 64'd0, 4'h4, 4'hF, 3'b000);
        vecs[13] = mk(1, 4'hC, 4'h0, 64'd5, 64'd6, 64'd7, 4'h2, 4'h3, 0, 0, 0,
                      1, 4'hC, 1, 64'd0, 64'd5, 4'h2, 4'h3, 3'b000);
        vecs[14] = mk(0, 4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h3, 4'hF, 0, 0, 0,
                      0, 4'h1, 0, 64'd0, 64'd0, 4'hF, 4'hF, 3'b000);
        vecs[15] = mk(1, 4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 0, 0, 0,
                      1, 4'h7, 1, 64'd0, 64'd0, 4'hF, 4'hF, 3'b000);
        vecs[16] = mk(1, 4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 0, 0, 0,
                      1, 4'h7, 0, 64'd0, 64'd0, 4'hF, 4'hF, 3'b000);
        vecs[17] = mk(1, 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h3, 4'hF, 0, 0, 0,
                      1, 4'h6, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h3, 4'hF, 3'b001);
        vecs[18] = mk(1, 4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 0, 0, 0,
                      1, 4'h7, 0, 64'd0, 64'd0, 4'hF, 4'hF, 3'b001);
        vecs[19] = mk(1, 4'h6, 4'h1, 64'd1, 64'd1, 64'd0, 4'h3, 4'hF, 0, 1, 0,
                      0, 4'h1, 0, 64'd0, 64'd0, 4'hF, 4'hF, 3'b001);
        vecs[20] = mk(1, 4'h6, 4'h0, 64'd2, 64'd3, 64'd0, 4'h7, 4'hF, 0, 0, 1,
                      1, 4'h6, 1, 64'd5, 64'd2, 4'h7, 4'hF, 3'b001);
        vecs[21] = mk(1, 4'h6, 4'h1, 64'd1, 64'd1, 64'd0, 4'h3, 4'hF, 1, 1, 0,
                      1, 4'h6, 1, 64'd5, 64'd2, 4'h7, 4'hF, 3'b001);
        vecs[22] = mk(1, 4'h7, 4'h0, 64'd9, 64'd0, 64'd0, 4'hF, 4'hF, 1, 0, 0,
                      1, 4'h6, 1, 64'd5, 64'd2, 4'h7, 4'hF, 3'b001);
        vecs[23] = mk(1, 4'h2, 4'h0, 64'hAB, 64'd0, 64'd0, 4'h9, 4'hF, 0, 0, 0,
                      1, 4'h2, 1, 64'hAB, 64'hAB, 4'h9, 4'hF, 3'b001);
        vecs[24] = mk(1, 4'h2, 4'h2, 64'hCD, 64'd0, 64'd0, 4'h8, 4'hF, 0, 0, 0,
                      1, 4'h2, 1, 64'hCD, 64'hCD, 4'h8, 4'hF, 3'b001);

        drive(0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_bubble("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].ic, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].c,
                  vecs[i].de, vecs[i].dm, vecs[i].st, vecs[i].fl, vecs[i].ch);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.valid", i), 64'(bus.e_valid), 64'(vecs[i].x_v));
            chk($sformatf("v%0d.icode", i), 64'(bus.e_icode), 64'(vecs[i].x_ic));
            chk($sformatf("v%0d.cnd", i),   64'(bus.e_cnd),   64'(vecs[i].x_cnd));
            chk($sformatf("v%0d.valE", i),  bus.e_valE,       vecs[i].x_e);
            chk($sformatf("v%0d.valA", i),  bus.e_valA,       vecs[i].x_a);
            chk($sformatf("v%0d.dstE", i),  64'(bus.e_dstE),  64'(vecs[i].x_de));
            chk($sformatf("v%0d.dstM", i),  64'(bus.e_dstM),  64'(vecs[i].x_dm));
            chk($sformatf("v%0d.cc", i),    64'(bus.cc_out),  64'(vecs[i].x_cc));
        end

        // Load a subq, then reset between edges while another subq is pending
        @(negedge clk);
        drive(1, 4'h6, 4'h1, 64'd1, 64'd3, 64'd0, 4'h3, 4'hF, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("pre_rst.valE", bus.e_valE, 64'd2);
        chk("pre_rst.cc", 64'(bus.cc_out), 64'b000);
        @(negedge clk);
        drive(1, 4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h3, 4'hF, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bubble("async_rst");
        @(negedge clk);
        drive(0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_bubble("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/y86_execute_stage.md
# y86_execute_stage

Registered execute stage for the Y86-64 datapath. It sits between decode and memory. Each cycle it selects the ALU operands and function from the decoded instruction and drives the existing `alu` block. It holds the condition-code register (ZF/SF/OF), evaluates jump and conditional-move conditions, and presents `valE`, `Cnd` and the squashed destinations to the memory stage one cycle later.

## Interface
Parameters:
- `WIDTH`, 64, datapath width. `alu` is fixed at 64, so only 64 is legal.
- `STACK_STEP`, 8, byte step for push/pop/call/ret.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `d_valid`  in  1  decode presents an instruction.
- `d_icode`, `d_ifun`  in  4 each  instruction code and function.
- `d_valA`, `d_valB`, `d_valC`  in  WIDTH each  operands.
- `d_dstE`, `d_dstM`  in  4 each  destination registers; `0xF` means none.
- `stall`  in  1  hold all outputs and CC.
- `flush`  in  1  load a bubble next edge.
- `cc_hold`  in  1  suppress the CC write this edge (a downstream exception is in flight).
- `e_valid`  out  1  output bundle valid.
- `e_icode`  out  4; `e_cnd`  out  1; `e_valE`  out  WIDTH; `e_valA`  out  WIDTH; `e_dstE`, `e_dstM`  out  4 each.
- `cc_out`  out  3  {ZF,SF,OF}, the current register contents.

## Operation
- ALU function: OPq (6) uses `ifun` (0 add, 1 sub, 2 and, 3 xor → control 00/01/10/11). All other instructions use add.
- aluA:
  - rrmovq/cmovXX (2) and OPq use valA.
  - irmovq (3), rmmovq (4) and mrmovq (5) use valC.
  - call (8) and pushq (A) use −STACK_STEP.
  - ret (9) and popq (B) use +STACK_STEP.
  - Anything else uses 0.
- aluB:
  - 4, 5, 6, 8, 9, A and B use valB.
  - 2 and 3 use 0.
  - Anything else uses 0.
- Operand order into `alu`: port a = aluB, port b = aluA. subq therefore yields valB − valA.
- New CC values: ZF = (result == 0), SF = result[63], OF = the `alu` overflow output for add/sub and forced to 0 for and/xor.
- CC write: only when `d_valid & icode==6 & !stall & !flush & !cc_hold`.
- Condition (`ifun`), evaluated on the current CC, before any update from this instruction:
  - 0 always; 1 le = (SF^OF)|ZF; 2 l = SF^OF; 3 e = ZF; 4 ne = !ZF; 5 ge = !(SF^OF); 6 g = !(SF^OF)&!ZF.
  - `ifun` > 6 gives Cnd = 0.
- Cnd is meaningful for icode 2 and 7. For every other icode it is 1.
- Conditional move with Cnd = 0: e_dstE = 0xF.
- icode > 0xB: passed through with e_valE = 0 and no CC write. The memory stage raises the exception.
- Bubble: e_valid = 0, e_icode = 1 (nop), e_dstE = e_dstM = 0xF, e_cnd = 0, e_valE = e_valA = 0.
- `d_valid` = 0 with no stall loads a bubble.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on `e_*` after edge N.
- `alu` is combinational inside the stage. Only the output bundle and CC are registered.
- Priority: reset > stall > flush > load.
  - `stall` holds every `e_*` and CC, even when `flush` is also asserted.
  - `flush` without `stall` loads a bubble and blocks the CC write.
- Asynchronous reset, including mid-instruction:
  - Outputs go to the bubble values immediately.
  - CC becomes {ZF=1, SF=0, OF=0}.
  - A pending CC write is lost.
- `cc_out` changes on the same edge that loads the OPq into `e_*`.
- A jXX in the following cycle sees the new CC.
- Arithmetic wraps modulo 2^64, and no flag other than OF reports the wrap.

## Structure
- `y86_pkg`: icode constants (HALT 0 … POPQ B), ALU function codes, condition codes, REG_NONE = 4'hF, and the bubble defaults.
- Sub-modules:
  - Instantiate the existing `alu` unchanged.
  - One new combinational sub-module, `cond_eval`: (CC, ifun) → Cnd.

## Test plan
- After reset: `cc_out` = 3'b100, e_valid = 0, e_icode = 1, e_dstE = 0xF.
- OPq subq, valA = 4, valB = 11 → e_valE = 7, CC = 000.
  - Then valA = 11, valB = 4 → e_valE = −7, CC = 010.
- addq, valA = 1, valB = 0x7FFF_FFFF_FFFF_FFFF → e_valE = 0x8000_0000_0000_0000, CC = 011.
  - Then a jl (ifun 2) → e_cnd = 0.
  - Then a jle with CC = 100 → e_cnd = 1.
- cmovne with ZF = 1, dstE = 3 → e_cnd = 0, e_dstE = 0xF, e_valE = valA.
- pushq, valB = 0x100 → e_valE = 0xF8. popq, valB = 0x100 → e_valE = 0x108. CC unchanged in both cases.
- Control inputs:
  - stall and flush together → outputs and CC held.
  - flush alone during an OPq → bubble, CC unchanged.
  - cc_hold during an OPq → valid e_valE, CC unchanged.
  - rst_n dropped mid-cycle → immediate bubble outputs and CC = 100.
